tristate: RTL and testbench

- Tri-state output driver: `y` follows `d` while `enable` is high and floats (high-Z) while `enable` is low.
- Used at chip/bus boundaries where several sources share one wire.
- Default build is a purely combinational drive path.
- A parameter selects a registered drive path, and an optional status block counts drive and float cycles for debug and verification.

---
 rtl/tristate.sv | 61 ++++++
 tb/tb_tristate.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tristate.sv
// Tri-state output driver with optional registered drive path (REG_OUT) and
// optional drive/float cycle counters enabled by the TRISTATE_STATUS_EN macro.
module tristate #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned REG_OUT = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output tri   [WIDTH-1:0] y,
  output logic             oe_q
`ifdef TRISTATE_STATUS_EN
  ,
  output logic [CNT_W-1:0] drive_cnt,
  output logic [CNT_W-1:0] hiz_cnt
`endif
);

  always_ff @(posedge clk) begin
    if (rst) oe_q <= 1'b0;
    else     oe_q <= enable;
  end

  generate
    if (REG_OUT != 0) begin : g_reg
      logic             en_r;
      logic [WIDTH-1:0] d_r;

      // Data is cleared on reset too, so re-enabling never exposes pre-reset data.
      always_ff @(posedge clk) begin
        if (rst) begin
          en_r <= 1'b0;
          d_r  <= '0;
        end else begin
          en_r <= enable;
          d_r  <= d;
        end
      end

      assign y = en_r ? d_r : 'z;
    end else begin : g_comb
      assign y = enable ? d : 'z;
    end
  endgenerate

`ifdef TRISTATE_STATUS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drive_cnt <= '0;
      hiz_cnt   <= '0;
    end else if (enable) begin
      if (drive_cnt != '1) drive_cnt <= drive_cnt + 1'b1;
    end else begin
      if (hiz_cnt != '1) hiz_cnt <= hiz_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tristate.sv
// Directed self-checking bench for tristate. Floating outputs are observed on
// pull-up and pull-down copies of each configuration: Z reads 1 on one, 0 on the other.
module tb_tristate;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       d1 = 1'b0;
  logic [7:0] d8 = 8'h00;

  int checks   = 0;
  int failures = 0;

  tri1       y_c0_pu;
  tri0       y_c0_pd;
  tri1 [7:0] y8_pu;
  tri0 [7:0] y8_pd;
  logic      oe_c0_pu, oe_c0_pd, oe_r8_pu, oe_r8_pd;
  logic [3:0] dcnt [4];
  logic [3:0] hcnt [4];

  always #5 clk = ~clk;

  tristate #(.WIDTH(1), .REG_OUT(0), .CNT_W(4)) u_c0_pu (
    .clk(clk), .rst(rst), .enable(enable), .d(d1), .y(y_c0_pu), .oe_q(oe_c0_pu)
`ifdef TRISTATE_STATUS_EN
    , .drive_cnt(dcnt[0]), .hiz_cnt(hcnt[0])
`endif
  );

  tristate #(.WIDTH(1), .REG_OUT(0), .CNT_W(4)) u_c0_pd (
    .clk(clk), .rst(rst), .enable(enable), .d(d1), .y(y_c0_pd), .oe_q(oe_c0_pd)
`ifdef TRISTATE_STATUS_EN
    , .drive_cnt(dcnt[1]), .hiz_cnt(hcnt[1])
`endif
  );

  tristate #(.WIDTH(8), .REG_OUT(1), .CNT_W(4)) u_r8_pu (
    .clk(clk), .rst(rst), .enable(enable), .d(d8), .y(y8_pu), .oe_q(oe_r8_pu)
`ifdef TRISTATE_STATUS_EN
    , .drive_cnt(dcnt[2]), .hiz_cnt(hcnt[2])
`endif
  );

  tristate #(.WIDTH(8), .REG_OUT(1), .CNT_W(4)) u_r8_pd (
    .clk(clk), .rst(rst), .enable(enable), .d(d8), .y(y8_pd), .oe_q(oe_r8_pd)
`ifdef TRISTATE_STATUS_EN
    , .drive_cnt(dcnt[3]), .hiz_cnt(hcnt[3])
`endif
  );

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; enable = 1'b1; d1 = 1'b1; d8 = 8'hFF;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({oe_c0_pu, oe_r8_pu} !== 2'b00) begin
      failures++; $display("FAIL reset_oe_q: got %b want 00", {oe_c0_pu, oe_r8_pu});
    end
    checks++;
    if ({y8_pu, y8_pd} !== 16'hFF00) begin
      failures++; $display("FAIL reset_reg_y_z: got pu=%h pd=%h want pu=ff pd=00", y8_pu, y8_pd);
    end
    checks++;
    if ({y_c0_pu, y_c0_pd} !== 2'b11) begin
      failures++; $display("FAIL reset_comb_y: got pu=%b pd=%b want 1 1", y_c0_pu, y_c0_pd);
    end
`ifdef TRISTATE_STATUS_EN
    checks++;
    if ({dcnt[0], hcnt[0]} !== 8'h00) begin
      failures++; $display("FAIL reset_counters: got drive=%h hiz=%h want 0 0", dcnt[0], hcnt[0]);
    end
`endif
    @(negedge clk);
    rst = 1'b0; enable = 1'b0;
  endtask

  task automatic test_comb_drive();
    enable = 1'b1; d1 = 1'b1; #10;
    checks++;
    if ({y_c0_pu, y_c0_pd} !== 2'b11) begin
      failures++; $display("FAIL comb_drive_1: got pu=%b pd=%b want 1 1", y_c0_pu, y_c0_pd);
    end
    d1 = 1'b0; #10;
    checks++;
    if ({y_c0_pu, y_c0_pd} !== 2'b00) begin
      failures++; $display("FAIL comb_drive_0: got pu=%b pd=%b want 0 0", y_c0_pu, y_c0_pd);
    end
    enable = 1'b0; #10;
    checks++;
    if ({y_c0_pu, y_c0_pd} !== 2'b10) begin
      failures++; $display("FAIL comb_float: got pu=%b pd=%b want 1 0 (z)", y_c0_pu, y_c0_pd);
    end
    d1 = 1'b1; enable = 1'b1; #3;
    checks++;
    if ({y_c0_pu, y_c0_pd} !== 2'b11) begin
      failures++; $display("FAIL comb_reenable_current_d: got pu=%b pd=%b want 1 1", y_c0_pu, y_c0_pd);
    end
  endtask

  task automatic test_comb_reset();
    @(negedge clk);
    rst = 1'b0; enable = 1'b1; d1 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (oe_c0_pu !== 1'b1) begin
      failures++; $display("FAIL comb_oe_q_set: got %b want 1", oe_c0_pu);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (oe_c0_pu !== 1'b0) begin
      failures++; $display("FAIL comb_oe_q_reset: got %b want 0", oe_c0_pu);
    end
    checks++;
    if ({y_c0_pu, y_c0_pd} !== 2'b11) begin
      failures++; $display("FAIL comb_y_during_reset: got pu=%b pd=%b want 1 1", y_c0_pu, y_c0_pd);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({oe_c0_pu, y_c0_pu, y_c0_pd} !== 3'b111) begin
      failures++; $display("FAIL comb_after_reset: got oe=%b y=%b%b want 1 11", oe_c0_pu, y_c0_pu, y_c0_pd);
    end
  endtask

  task automatic test_reg_drive();
    @(negedge clk);
    rst = 1'b1; enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; enable = 1'b1; d8 = 8'hA5; #1;
    checks++;
    if ({y8_pu, y8_pd} !== 16'hFF00) begin
      failures++; $display("FAIL reg_z_before_edge: got pu=%h pd=%h want ff 00", y8_pu, y8_pd);
    end
    @(posedge clk); #1;
    checks++;
    if ({y8_pu, y8_pd, oe_r8_pu} !== {8'hA5, 8'hA5, 1'b1}) begin
      failures++; $display("FAIL reg_drive_a5: got pu=%h pd=%h oe=%b want a5 a5 1", y8_pu, y8_pd, oe_r8_pu);
    end
    @(negedge clk);
    d8 = 8'h3C; #1;
    checks++;
    if ({y8_pu, y8_pd} !== 16'hA5A5) begin
      failures++; $display("FAIL reg_latency_hold: got pu=%h pd=%h want a5 a5", y8_pu, y8_pd);
    end
    @(posedge clk); #1;
    checks++;
    if ({y8_pu, y8_pd} !== 16'h3C3C) begin
      failures++; $display("FAIL reg_drive_3c: got pu=%h pd=%h want 3c 3c", y8_pu, y8_pd);
    end
    @(negedge clk);
    enable = 1'b0; d8 = 8'h5A; #1;
    checks++;
    if ({y8_pu, y8_pd} !== 16'h3C3C) begin
      failures++; $display("FAIL reg_release_latency: got pu=%h pd=%h want 3c 3c", y8_pu, y8_pd);
    end
    @(posedge clk); #1;
    checks++;
    if ({y8_pu, y8_pd, oe_r8_pu} !== {8'hFF, 8'h00, 1'b0}) begin
      failures++; $display("FAIL reg_release: got pu=%h pd=%h oe=%b want ff 00 0", y8_pu, y8_pd, oe_r8_pu);
    end
    @(negedge clk);
    enable = 1'b1; d8 = 8'h96;
    @(posedge clk); #1;
    checks++;
    if ({y8_pu, y8_pd} !== 16'h9696) begin
      failures++; $display("FAIL reg_reenable_fresh_d: got pu=%h pd=%h want 96 96", y8_pu, y8_pd);
    end
  endtask

  task automatic test_reg_reset_middrive();
    @(negedge clk);
    rst = 1'b0; enable = 1'b1; d8 = 8'hC3;
    @(posedge clk); #1;
    checks++;
    if ({y8_pu, y8_pd} !== 16'hC3C3) begin
      failures++; $display("FAIL middrive_pre: got pu=%h pd=%h want c3 c3", y8_pu, y8_pd);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({y8_pu, y8_pd, oe_r8_pu} !== {8'hFF, 8'h00, 1'b0}) begin
      failures++; $display("FAIL middrive_reset: got pu=%h pd=%h oe=%b want ff 00 0", y8_pu, y8_pd, oe_r8_pu);
    end
    @(negedge clk);
    rst = 1'b0; enable = 1'b0;
  endtask

`ifdef TRISTATE_STATUS_EN
  task automatic test_status();
    @(negedge clk);
    rst = 1'b1; enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({dcnt[0], hcnt[0]} !== 8'h50) begin
      failures++; $display("FAIL status_drive_5: got drive=%h hiz=%h want 5 0", dcnt[0], hcnt[0]);
    end
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if ({dcnt[0], hcnt[0]} !== 8'hF0) begin
      failures++; $display("FAIL status_drive_sat: got drive=%h hiz=%h want f 0", dcnt[0], hcnt[0]);
    end
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({dcnt[0], hcnt[0]} !== 8'hF3) begin
      failures++; $display("FAIL status_hiz_3: got drive=%h hiz=%h want f 3", dcnt[0], hcnt[0]);
    end
  endtask
`endif

  task automatic test_enable_x();
    logic probe;
    probe = 1'bx;
    // Only meaningful on a four-state simulator.
    if ($isunknown(probe)) begin
      enable = 1'bx; d1 = 1'b1; #10;
      checks++;
      if (y_c0_pu !== 1'bx || y_c0_pd !== 1'bx) begin
        failures++; $display("FAIL enable_x: got pu=%b pd=%b want x x", y_c0_pu, y_c0_pd);
      end
      enable = 1'b1; d1 = 1'bx; #10;
      checks++;
      if (y_c0_pu !== 1'bx || y_c0_pd !== 1'bx) begin
        failures++; $display("FAIL data_x: got pu=%b pd=%b want x x", y_c0_pu, y_c0_pd);
      end
      enable = 1'b0; d1 = 1'b0; #10;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_comb_drive();
    test_comb_reset();
    test_reg_drive();
    test_reg_reset_middrive();
`ifdef TRISTATE_STATUS_EN
    test_status();
`endif
    test_enable_x();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
